// File: rtl/lcd_fb_arbiter.sv
// 64-byte LCD character framebuffer: refresh-engine read port has priority,
// two round-robin write clients share the rest, and a fill engine clears it.
module lcd_fb_arbiter #(
    parameter int         ROWS      = 4,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_en,
    input  logic [5:0]      rd_addr,
    output logic [7:0]      rd_data,
    input  logic            wr0_valid,
    input  logic [5:0]      wr0_addr,
    input  logic [7:0]      wr0_data,
    output logic            wr0_ready,
    input  logic            wr1_valid,
    input  logic [5:0]      wr1_addr,
    input  logic [7:0]      wr1_data,
    output logic            wr1_ready,
    input  logic            fill_start,
    output logic            busy,
    output logic [ROWS-1:0] row_dirty,
    input  logic [ROWS-1:0] row_ack
);

    localparam int DEPTH = ROWS * 16;

    typedef enum logic {
        S_FILL,
        S_SERVE
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      fill_cnt_q, fill_cnt_d;
    logic            last_grant_q, last_grant_d;
    logic [ROWS-1:0] dirty_q, dirty_d;
    logic [ROWS-1:0] dirty_set;
    logic [7:0]      rd_data_q;
    logic [7:0]      mem_q [DEPTH];

    logic            we;
    logic [5:0]      waddr;
    logic [7:0]      wdata;

    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        last_grant_d = last_grant_q;
        wr0_ready    = 1'b0;
        wr1_ready    = 1'b0;
        we           = 1'b0;
        waddr        = fill_cnt_q;
        wdata        = FILL_CHAR;
        dirty_set    = '0;

        if (state_q == S_FILL) begin
            if (!rd_en) begin
                we         = 1'b1;
                fill_cnt_d = fill_cnt_q + 6'd1;
                if (fill_cnt_q == 6'd63) begin
                    state_d = S_SERVE;
                end
            end
        end else if (!rd_en) begin
            // On a tie the client that did not win last time gets the slot.
            if (wr0_valid && (!wr1_valid || last_grant_q)) begin
                wr0_ready = 1'b1;
            end else if (wr1_valid) begin
                wr1_ready = 1'b1;
            end

            if (wr0_ready) begin
                we           = 1'b1;
                waddr        = wr0_addr;
                wdata        = wr0_data;
                last_grant_d = 1'b0;
            end else if (wr1_ready) begin
                we           = 1'b1;
                waddr        = wr1_addr;
                wdata        = wr1_data;
                last_grant_d = 1'b1;
            end
        end

        if (fill_start) begin
            state_d    = S_FILL;
            fill_cnt_d = 6'd0;
        end

        for (int r = 0; r < ROWS; r++) begin
            if (we && (waddr[5:4] == 2'(r))) begin
                dirty_set[r] = 1'b1;
            end
        end
        dirty_d = (dirty_q & ~row_ack) | dirty_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FILL;
            fill_cnt_q   <= 6'd0;
            last_grant_q <= 1'b1;
            dirty_q      <= {ROWS{1'b1}};
            rd_data_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            last_grant_q <= last_grant_d;
            dirty_q      <= dirty_d;
            if (rd_en) begin
                rd_data_q <= mem_q[rd_addr];
            end
        end
    end

    // Storage has no reset; writes are suppressed while rst is held.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rd_data   = rd_data_q;
    assign busy      = (state_q == S_FILL);
    assign row_dirty = dirty_q;

endmodule
